rv32i_lsu_multicycle: RTL

Parametrised multicycle load/store unit for the RV32I multicycle core. It takes one load or store request at a time and performs the access on the core's shared single-port memory interface, which has no byte enables. Sub-word stores are done as read-modify-write. It implements LB/LH/LW/LBU/LHU/SB/SH/SW, supports configurable memory read latency, and detects misaligned and illegal accesses.

---
 rtl/rv32i_defines.sv | 49 ++++
 rtl/register.sv | 28 ++
 rtl/rv32i_lsu_lanes.sv | 55 +++++
 rtl/rv32i_lsu_multicycle.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/rv32i_defines.sv
// Shared RV32I definitions: load/store funct3 codes and the LSU request record.
// Latency: n/a (constants, types and a combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   FUNCT3_*          funct3 encodings for the RV32I load and store instructions
//   lsu_req_t         request fields held by the load/store unit for one access
//   lsu_access_error  illegal-funct3 / misalignment check for a load or store
package rv32i_defines;

  // Loads
  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  // Stores
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  // Only the byte offset of the address is kept; the word part lives in the
  // unit's mem_addr register, which already holds it for the whole access.
  typedef struct packed {
    logic        write;
    logic [2:0]  funct3;
    logic [1:0]  addr_lo;
    logic [31:0] wdata;
  } lsu_req_t;

  // funct3[1:0] encodes the access size (0 byte, 1 half, 2 word) for every
  // legal load and store, so alignment is checked from those two bits.
  function automatic logic lsu_access_error(input logic       write,
                                            input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
    logic illegal;
    logic misaligned;
    if (write) begin
      illegal = (funct3 > FUNCT3_SW);
    end else begin
      illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    end
    misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/register.sv
// Generic load-enabled register cell.
// Latency: 1 cycle from d to q when ena is high.
// Backpressure: none; ena low simply holds the stored value.
//
// Ports:
//   clk, rst  clock and synchronous active-high reset (q <= RESET_VALUE)
//   ena       load enable
//   d / q     data in / registered data out, WIDTH bits
module register #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else if (ena) begin
      q <= d;
    end
  end

endmodule

// File: rtl/rv32i_lsu_lanes.sv
// Byte/halfword lane steering for the LSU: load extraction and store merge.
// Latency: 0 (purely combinational).
// Backpressure: n/a.
//
// Ports:
//   word       memory word being read (or previously captured)
//   addr_lo    byte offset of the access within the word
//   funct3     RV32I load/store funct3
//   wdata      store data, sub-word stores use the low lanes
//   load_data  extracted and sign/zero-extended load result (0 for illegal funct3)
//   store_word word with the store lanes merged into it
module rv32i_lsu_lanes
  import rv32i_defines::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    load_data = '0;
    case (funct3)
      FUNCT3_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      FUNCT3_LH:  load_data = {{16{half_sel[15]}}, half_sel};
      FUNCT3_LW:  load_data = word;
      FUNCT3_LBU: load_data = {24'h0, byte_sel};
      FUNCT3_LHU: load_data = {16'h0, half_sel};
      default:    load_data = '0;
    endcase

    store_word = word;
    case (funct3)
      FUNCT3_SB: store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      FUNCT3_SH: begin
        if (addr_lo[1]) begin
          store_word[31:16] = wdata[15:0];
        end else begin
          store_word[15:0] = wdata[15:0];
        end
      end
      FUNCT3_SW: store_word = wdata;
      default:   store_word = word;
    endcase
  end

endmodule

// File: rtl/rv32i_lsu_multicycle.sv
// Multicycle RV32I load/store unit on a single-port memory without byte enables.
// Latency: load L+2, SW 2, SB/SH L+3 (read-modify-write), error 1 cycle; +1 per ena-low cycle.
// Backpressure: one request in flight; req_ready only in idle; response cannot be stalled.
//
// Ports:
//   clk, rst, ena       clock, synchronous active-high reset, global freeze
//   req_*               request handshake (valid/ready) and load/store fields
//   rsp_*               one-cycle response: load data and error flag
//   mem_*               word-aligned memory address, write data/strobe, read data
//   accesses_completed  running count of responses, errors included
module rv32i_lsu_multicycle
  import rv32i_defines::*;
#(
  parameter int MEM_LATENCY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr_ena,
  input  logic [31:0] mem_rd_data,
  output logic [31:0] accesses_completed
);

  localparam int LAT_CW = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  lsu_req_t          req_d, req_q;
  logic              accept;
  logic              req_err;
  logic              req_is_sw;
  logic [LAT_CW-1:0] lat_cnt_q;
  logic              lat_last;
  logic [31:0]       rd_word_q;
  logic              err_q;
  logic [31:0]       lanes_word;
  logic [31:0]       load_data;
  logic [31:0]       store_word;

  assign accept    = req_valid & req_ready;
  assign req_err   = lsu_access_error(req_write, req_funct3, req_addr[1:0]);
  assign req_is_sw = req_write & (req_funct3 == FUNCT3_SW);
  assign lat_last  = (lat_cnt_q == LAT_CW'(MEM_LATENCY));

  assign req_d = '{write: req_write, funct3: req_funct3,
                   addr_lo: req_addr[1:0], wdata: req_wdata};

  register #(
    .WIDTH($bits(lsu_req_t))
  ) u_req_reg (
    .clk (clk),
    .rst (rst),
    .ena (accept),
    .d   (req_d),
    .q   (req_q)
  );

  // The lanes see the live memory word while reading (store merge happens on
  // the sampling edge) and the captured word afterwards (load extraction for
  // the response), so one instance serves both paths.
  assign lanes_word = (state_q == S_READ) ? mem_rd_data : rd_word_q;

  rv32i_lsu_lanes u_lanes (
    .word       (lanes_word),
    .addr_lo    (req_q.addr_lo),
    .funct3     (req_q.funct3),
    .wdata      (req_q.wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Every strobe is qualified by ena and ~rst so a frozen or resetting unit
  // never writes memory, accepts a request or emits a response.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    mem_wr_ena = 1'b0;
    if (ena && !rst) begin
      case (state_q)
        S_IDLE: begin
          req_ready = 1'b1;
          if (req_valid) begin
            if (req_err) begin
              state_d = S_RESP;
            end else if (req_is_sw) begin
              state_d = S_WRITE;
            end else begin
              state_d = S_READ;
            end
          end
        end
        S_READ: begin
          if (lat_last) begin
            state_d = req_q.write ? S_WRITE : S_RESP;
          end
        end
        S_WRITE: begin
          mem_wr_ena = 1'b1;
          state_d    = S_RESP;
        end
        S_RESP: begin
          rsp_valid = 1'b1;
          state_d   = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt_q          <= '0;
      rd_word_q          <= '0;
      err_q              <= 1'b0;
      mem_addr           <= '0;
      mem_wr_data        <= '0;
      accesses_completed <= '0;
    end else if (ena) begin
      if (accept) begin
        lat_cnt_q <= '0;
        err_q     <= req_err;
        // An erroring request leaves the memory port exactly as it was.
        if (!req_err) begin
          mem_addr <= {req_addr[31:2], 2'b00};
        end
        if (!req_err && req_is_sw) begin
          mem_wr_data <= req_wdata;
        end
      end
      if (state_q == S_READ) begin
        if (lat_last) begin
          rd_word_q <= mem_rd_data;
          if (req_q.write) begin
            mem_wr_data <= store_word;
          end
        end else begin
          lat_cnt_q <= lat_cnt_q + LAT_CW'(1);
        end
      end
      if (state_q == S_RESP) begin
        accesses_completed <= accesses_completed + 32'd1;
      end
    end
  end

  assign rsp_error = rsp_valid & err_q;
  assign rsp_rdata = (rsp_valid && !err_q && !req_q.write) ? load_data : 32'h0;

endmodule
